mdu_ctrl: RTL and testbench

MDU_CTRL -- requirements
Module: mdu_ctrl

---
 rtl/mdu_pkg.sv | 29 ++
 rtl/mdu_arith.sv | 59 +++++
 rtl/mdu_ctrl.sv | 108 ++++++++++
 tb/tb_mdu_ctrl.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings, latencies, FSM state.
package mdu_pkg;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;
  localparam logic [2:0] OP_MFHI  = 3'd6;
  localparam logic [2:0] OP_MFLO  = 3'd7;

  localparam logic [3:0] MUL_LAT = 4'd5;
  localparam logic [3:0] DIV_LAT = 4'd10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  function automatic logic is_mult(input logic [2:0] op);
    return (op == OP_MULT) || (op == OP_MULTU);
  endfunction

  function automatic logic is_div(input logic [2:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational MDU datapath: 32x32 multiply and (with MDU_DIV_EN) a shared signed/unsigned divider.
module mdu_arith
  import mdu_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] hi_n,
  output logic [31:0] lo_n,
  output logic        div0
);

  logic        sgn;
  logic [63:0] ax;
  logic [63:0] bx;
  logic [63:0] prod;

  // Sign- or zero-extending to 64 bits lets one truncated multiplier serve MULT and MULTU.
  always_comb begin
    sgn  = (op == OP_MULT) || (op == OP_DIV);
    ax   = sgn ? {{32{a[31]}}, a} : {32'd0, a};
    bx   = sgn ? {{32{b[31]}}, b} : {32'd0, b};
    prod = ax * bx;
  end

`ifdef MDU_DIV_EN
  logic        a_neg;
  logic        b_neg;
  logic [31:0] ua;
  logic [31:0] ub;
  logic [31:0] q;
  logic [31:0] r;

  // Magnitude divide, then fix signs; 0x80000000 / -1 falls out as 0x80000000 rem 0.
  always_comb begin
    div0  = (b == 32'd0);
    a_neg = sgn & a[31];
    b_neg = sgn & b[31];
    ua    = a_neg ? (32'd0 - a) : a;
    ub    = div0 ? 32'd1 : (b_neg ? (32'd0 - b) : b);
    q     = ua / ub;
    r     = ua % ub;
    if (is_div(op)) begin
      lo_n = (a_neg ^ b_neg) ? (32'd0 - q) : q;
      hi_n = a_neg ? (32'd0 - r) : r;
    end else begin
      hi_n = prod[63:32];
      lo_n = prod[31:0];
    end
  end
`else
  always_comb begin
    div0 = 1'b0;
    hi_n = prod[63:32];
    lo_n = prod[31:0];
  end
`endif

endmodule

// File: rtl/mdu_ctrl.sv
// MDU controller: issue FSM, latency down-counter and HI/LO registers.
// Divide support is built only when MDU_DIV_EN is defined; otherwise DIV/DIVU are no-ops.
//
// state   | meaning
// ST_IDLE | accepts start; MTHI/MTLO write immediately, MULT/DIV latch operands
// ST_BUSY | counting down; HI/LO written on the 1->0 count edge
module mdu_ctrl
  import mdu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  mdu_op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        d_mdu_use,
  output logic        stall,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] rd_data
);

  state_e      state;
  logic [3:0]  cnt;
  logic [2:0]  op_q;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic [31:0] hi_n;
  logic [31:0] lo_n;
  logic        div0;
  logic        div_launch;
  logic        long_op;

`ifdef MDU_DIV_EN
  assign div_launch = is_div(mdu_op);
`else
  assign div_launch = 1'b0;
`endif

  assign long_op = is_mult(mdu_op) | div_launch;

  // Gated by reset so stall drops the instant reset asserts, even with start held.
  assign stall = d_mdu_use & (busy | (start & long_op & reset));

  always_comb begin
    rd_data = 32'd0;
    if (mdu_op == OP_MFHI)      rd_data = hi;
    else if (mdu_op == OP_MFLO) rd_data = lo;
  end

  mdu_arith u_arith (
    .op   (op_q),
    .a    (a_q),
    .b    (b_q),
    .hi_n (hi_n),
    .lo_n (lo_n),
    .div0 (div0)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
      cnt   <= 4'd0;
      busy  <= 1'b0;
      op_q  <= OP_MULT;
      a_q   <= 32'd0;
      b_q   <= 32'd0;
      hi    <= 32'd0;
      lo    <= 32'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            if (long_op) begin
              op_q  <= mdu_op;
              a_q   <= src_a;
              b_q   <= src_b;
              cnt   <= is_mult(mdu_op) ? MUL_LAT : DIV_LAT;
              busy  <= 1'b1;
              state <= ST_BUSY;
            end else if (mdu_op == OP_MTHI) begin
              hi <= src_a;
            end else if (mdu_op == OP_MTLO) begin
              lo <= src_a;
            end
          end
        end
        ST_BUSY: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
            if (!div0) begin
              hi <= hi_n;
              lo <= lo_n;
            end
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed self-checking bench for mdu_ctrl; divide cases follow MDU_DIV_EN.
module tb_mdu_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  mdu_op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        d_mdu_use;
  logic        stall;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] rd_data;

  int checks = 0;
  int errors = 0;

  mdu_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .mdu_op    (mdu_op),
    .src_a     (src_a),
    .src_b     (src_b),
    .d_mdu_use (d_mdu_use),
    .stall     (stall),
    .busy      (busy),
    .hi        (hi),
    .lo        (lo),
    .rd_data   (rd_data)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    mdu_op = op;
    src_a  = a;
    src_b  = b;
    start  = 1'b1;
    tick();
    start  = 1'b0;
  endtask

  // Expects busy (and stall = exp_stall) for n cycles, then busy low.
  task automatic expect_busy(input string tag, input int n, input logic exp_stall);
    for (int i = 0; i < n; i++) begin
      chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
      chk({tag, "_stall"}, {31'd0, stall}, {31'd0, exp_stall});
      tick();
    end
    chk({tag, "_done"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; mdu_op = 3'd0;
    src_a = 32'd0; src_b = 32'd0; d_mdu_use = 1'b0;
    #12;
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    reset = 1'b1;
    tick();

    // MULT -2 * 3 with D-stage MDU use held: stall in start cycle plus 5 busy cycles
    d_mdu_use = 1'b1;
    mdu_op = 3'd0; src_a = 32'hFFFF_FFFE; src_b = 32'd3; start = 1'b1;
    #1;
    chk("mult_start_stall", {31'd0, stall}, 32'd1);
    chk("mult_start_busy", {31'd0, busy}, 32'd0);
    tick();
    start = 1'b0;
    expect_busy("mult", 5, 1'b1);
    chk("mult_after_stall", {31'd0, stall}, 32'd0);
    chk("mult_hi", hi, 32'hFFFF_FFFF);
    chk("mult_lo", lo, 32'hFFFF_FFFA);
    d_mdu_use = 1'b0;

    mdu_op = 3'd6; #1;
    chk("mfhi", rd_data, 32'hFFFF_FFFF);
    mdu_op = 3'd7; #1;
    chk("mflo", rd_data, 32'hFFFF_FFFA);
    mdu_op = 3'd4; #1;
    chk("rd_other", rd_data, 32'd0);

    // MULTU with an MTLO attempted mid-flight: must be ignored
    issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    chk("multu_c1", {31'd0, busy}, 32'd1);
    tick();
    mdu_op = 3'd5; src_a = 32'hDEAD_BEEF; start = 1'b1;
    tick();
    start = 1'b0;
    chk("multu_lo_hold", lo, 32'hFFFF_FFFA);
    tick();
    tick();
    chk("multu_c5", {31'd0, busy}, 32'd1);
    tick();
    chk("multu_done", {31'd0, busy}, 32'd0);
    chk("multu_hi", hi, 32'hFFFF_FFFE);
    chk("multu_lo", lo, 32'h0000_0001);

    issue(3'd4, 32'h0000_1234, 32'd0);
    chk("mthi", hi, 32'h0000_1234);
    chk("mthi_busy", {31'd0, busy}, 32'd0);
    issue(3'd5, 32'h0000_5678, 32'd0);
    chk("mtlo", lo, 32'h0000_5678);

`ifdef MDU_DIV_EN
    issue(3'd3, 32'd7, 32'd2);
    expect_busy("divu", 10, 1'b0);
    chk("divu_lo", lo, 32'd3);
    chk("divu_hi", hi, 32'd1);
    issue(3'd2, 32'hFFFF_FFF9, 32'd2);
    expect_busy("div", 10, 1'b0);
    chk("div_lo", lo, 32'hFFFF_FFFD);
    chk("div_hi", hi, 32'hFFFF_FFFF);
    issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    expect_busy("div_ovf", 10, 1'b0);
    chk("div_ovf_lo", lo, 32'h8000_0000);
    chk("div_ovf_hi", hi, 32'd0);
    issue(3'd4, 32'h0000_1234, 32'd0);
    issue(3'd2, 32'd5, 32'd0);
    expect_busy("div0", 10, 1'b0);
    chk("div0_hi", hi, 32'h0000_1234);
    chk("div0_lo", lo, 32'h8000_0000);
    // Reset during busy cycle 3 of a DIV
    d_mdu_use = 1'b1;
    issue(3'd2, 32'd100, 32'd7);
    tick();
    tick();
    chk("divrst_pre", {31'd0, busy}, 32'd1);
    reset = 1'b0;
    #1;
    chk("divrst_busy", {31'd0, busy}, 32'd0);
    chk("divrst_stall", {31'd0, stall}, 32'd0);
    chk("divrst_hi", hi, 32'd0);
    chk("divrst_lo", lo, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    d_mdu_use = 1'b0;
    for (int i = 0; i < 12; i++) tick();
    chk("divrst_post_hi", hi, 32'd0);
    chk("divrst_post_lo", lo, 32'd0);
    issue(3'd4, 32'h0000_1234, 32'd0);
    issue(3'd5, 32'h0000_5678, 32'd0);
`else
    d_mdu_use = 1'b1;
    mdu_op = 3'd2; src_a = 32'd7; src_b = 32'd2; start = 1'b1;
    #1;
    chk("nodiv_stall", {31'd0, stall}, 32'd0);
    tick();
    start = 1'b0;
    chk("nodiv_busy", {31'd0, busy}, 32'd0);
    issue(3'd3, 32'd7, 32'd2);
    chk("nodivu_busy", {31'd0, busy}, 32'd0);
    for (int i = 0; i < 11; i++) tick();
    chk("nodiv_hi", hi, 32'h0000_1234);
    chk("nodiv_lo", lo, 32'h0000_5678);
    d_mdu_use = 1'b0;
`endif

    // Reset during busy cycle 3 of a MULT
    d_mdu_use = 1'b1;
    issue(3'd0, 32'd3, 32'd4);
    tick();
    tick();
    chk("mulrst_pre", {31'd0, busy}, 32'd1);
    reset = 1'b0;
    #1;
    chk("mulrst_busy", {31'd0, busy}, 32'd0);
    chk("mulrst_stall", {31'd0, stall}, 32'd0);
    chk("mulrst_hi", hi, 32'd0);
    chk("mulrst_lo", lo, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    d_mdu_use = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    chk("mulrst_post_hi", hi, 32'd0);
    chk("mulrst_post_lo", lo, 32'd0);
    chk("mulrst_post_busy", {31'd0, busy}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
